// File: rtl/row_result_collector.sv
// Row result collector: bias add, activation, output vector with valid/ack.
// Define COLLECTOR_SATURATE_EN to saturate the biased sum instead of wrapping.
module row_result_collector #(
  parameter int N_ROWS   = 16,
  parameter int QN       = 6,
  parameter int QM       = 11,
  parameter int ACT_TYPE = 1,
  localparam int BITWIDTH = QN + QM + 1,
  localparam int RW = $clog2(N_ROWS),
  localparam int CW = $clog2(N_ROWS + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dataReady,
  input  logic [BITWIDTH-1:0]          finalResult,
  input  logic [N_ROWS*BITWIDTH-1:0]   biasVector,
  output logic [RW-1:0]                rowIdx,
  output logic [N_ROWS*BITWIDTH-1:0]   outputVector,
  output logic                         vectorValid,
  input  logic                         vectorAck,
  output logic                         overflow
);

  localparam int BW = BITWIDTH;

  localparam logic signed [BW:0] ONE_E =
    {{(BW-QM){1'b0}}, 1'b1, {QM{1'b0}}};
  localparam logic signed [BW:0] HALF_E = ONE_E >>> 1;
  localparam logic signed [BW:0] NEG_ONE_E = -ONE_E;
  localparam logic signed [BW:0] ZERO_E = '0;
  localparam logic signed [BW:0] SMAX =
    {2'b00, {(BW-1){1'b1}}};
  localparam logic signed [BW:0] SMIN =
    {2'b11, {(BW-1){1'b0}}};

  typedef enum logic [1:0] {
    COLLECT,
    FLUSH,
    DONE
  } state_t;

  state_t state;
  logic [CW-1:0] count;

  logic                 s1_valid;
  logic signed [BW:0]   s1_sum;
  logic [RW-1:0]        s1_row;

  logic                 accept;
  logic                 drop;
  logic [BW-1:0]        bias_sel;
  logic signed [BW:0]   sum_next;
  logic [BW-1:0]        red;
  logic signed [BW:0]   xe;
  logic signed [BW:0]   hs;
  logic signed [BW:0]   act_w;
  logic [BW-1:0]        act_y;

  // Accept decision, bias lookup and S1 sum at full width.
  always_comb begin
    accept = dataReady &&
             ((state == COLLECT) ||
              ((state == DONE) && vectorAck));
    drop = dataReady && !accept;
    bias_sel = biasVector[rowIdx*BW +: BW];
    sum_next = {finalResult[BW-1], finalResult} +
               {bias_sel[BW-1], bias_sel};
  end

  // S2: reduce the sum to BITWIDTH and apply the activation.
  always_comb begin
`ifdef COLLECTOR_SATURATE_EN
    if (s1_sum > SMAX)
      red = SMAX[BW-1:0];
    else if (s1_sum < SMIN)
      red = SMIN[BW-1:0];
    else
      red = s1_sum[BW-1:0];
`else
    red = s1_sum[BW-1:0];
`endif
    xe = {red[BW-1], red};
    hs = (xe >>> 2) + HALF_E;
    act_w = xe;
    case (ACT_TYPE)
      0: act_w = xe;
      1: begin
        if (hs < ZERO_E)
          act_w = ZERO_E;
        else if (hs > ONE_E)
          act_w = ONE_E;
        else
          act_w = hs;
      end
      default: begin
        if (xe > ONE_E)
          act_w = ONE_E;
        else if (xe < NEG_ONE_E)
          act_w = NEG_ONE_E;
        else
          act_w = xe;
      end
    endcase
    act_y = act_w[BW-1:0];
  end

  // Control FSM, S1 pipeline register and output vector writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= COLLECT;
      count        <= '0;
      rowIdx       <= '0;
      s1_valid     <= 1'b0;
      s1_sum       <= '0;
      s1_row       <= '0;
      outputVector <= '0;
      vectorValid  <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_sum <= sum_next;
        s1_row <= rowIdx;
        if (rowIdx == RW'(N_ROWS - 1))
          rowIdx <= '0;
        else
          rowIdx <= rowIdx + 1'b1;
      end
      if (s1_valid)
        outputVector[s1_row*BW +: BW] <= act_y;
      if (drop)
        overflow <= 1'b1;
      unique case (state)
        COLLECT: begin
          if (accept) begin
            if (count == CW'(N_ROWS - 1)) begin
              count <= '0;
              state <= FLUSH;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (!s1_valid) begin
            state       <= DONE;
            vectorValid <= 1'b1;
          end
        end
        DONE: begin
          if (vectorAck) begin
            state       <= COLLECT;
            vectorValid <= 1'b0;
            count       <= accept ? CW'(1) : '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: doc/row_result_collector.md
Name: row_result_collector

Overview:
- Downstream stage of the row dot-product unit. Samples each per-row scalar result on that unit's one-cycle dataReady pulse.
- Adds a per-row bias and applies a fixed-point activation. Writes the result into an N_ROWS-entry output vector.
- Presents the full vector to the next layer/state register with a valid/ack handshake.
- All values are signed fixed-point Q(QN).(QM), BITWIDTH = QN+QM+1.

Parameters:
N_ROWS, 16, rows per output vector; must be >= 2
QN, 6, integer bits (excluding sign)
QM, 11, fractional bits; 1.0 = 2^QM
ACT_TYPE, 1, 0 = identity, 1 = hard sigmoid, 2 = hard tanh

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dataReady  in  1  one-cycle pulse, finalResult valid
finalResult  in  BITWIDTH  signed row dot-product result
biasVector  in  N_ROWS*BITWIDTH  signed biases; row r is at [r*BITWIDTH +: BITWIDTH]; must be static while collecting
rowIdx  out  log2(N_ROWS)  index the next accepted row is written to
outputVector  out  N_ROWS*BITWIDTH  activated results, same packing as biasVector
vectorValid  out  1  all N_ROWS rows written
vectorAck  in  1  consumer accepts the vector
overflow  out  1  sticky: a dataReady pulse was dropped

Behaviour:
- Reset: state=COLLECT, rowIdx=0, accepted-row count=0, pipeline valids=0, vectorValid=0, overflow=0, outputVector=0. A reset mid-collection discards partial rows and in-flight data.
- States:
  - COLLECT: accepts dataReady pulses. Goes to FLUSH when the N_ROWS-th row is accepted.
  - FLUSH: waits for the pipeline to drain. Goes to DONE in the cycle the last row is written.
  - DONE: vectorValid=1. Goes to COLLECT on vectorAck.
- Accept, in COLLECT: latch finalResult and the row index. Increment rowIdx, wrapping to 0 after N_ROWS-1.
- Pipeline, 2 stages:
  - S1 register: sum = finalResult + bias[row], computed at BITWIDTH+1 bits.
  - S2: reduce sum to BITWIDTH (saturate or wrap, see Optional Feature). Apply activation and write outputVector[row].
  - A dataReady at cycle t is visible in outputVector at t+2.
  - Back-to-back pulses are sustained at 1 row/cycle.
- Activation, with one = 2^QM:
  - Identity: y = x.
  - Hard sigmoid: y = clamp((x >>> 2) + one/2, 0, one). Use an arithmetic shift.
  - Hard tanh: y = clamp(x, -one, one).
- vectorValid:
  - Asserts the cycle after the last row's S2 write (state=DONE) and holds until vectorAck is sampled high.
  - outputVector is stable while vectorValid=1.
- vectorAck handling:
  - When vectorValid=0, vectorAck is ignored.
  - On ack: vectorValid=0 next cycle and state=COLLECT. The count is cleared; rowIdx is already 0.
  - outputVector keeps its old contents until each row is overwritten.
- dataReady in FLUSH, or in DONE without a same-cycle vectorAck: the pulse is dropped and overflow is set.
- dataReady in DONE with a same-cycle vectorAck: the pulse is accepted as row 0 of the next vector, with no drop.
- overflow clears only on reset.

Optional Feature:
- Macro: COLLECTOR_SATURATE_EN.
- Defined: the BITWIDTH+1-bit sum clamps to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1] before activation.
- Undefined: the sum is truncated to its low BITWIDTH bits (two's-complement wrap).
- Activation clamps are unaffected either way.

Test Plan:
1. Default parameters, ACT_TYPE=2, all biases 0. Drive 16 back-to-back pulses with finalResult 3000, -3000, 1000, then 0 for the rest. Required: out[0]=2048, out[1]=-2048, out[2]=1000; vectorValid rises exactly 3 cycles after the 16th pulse.
2. ACT_TYPE=1. finalResult=0 with bias 0 gives 1024. finalResult=4096 gives 2048. finalResult=-8192 gives 0. finalResult=400 with bias 100 gives 1149.
3. ACT_TYPE=0. finalResult=131071 with bias 1. Required: 131071 with COLLECTOR_SATURATE_EN defined, -131072 without. Also -131072 with bias -1 gives -131072 saturated, 131071 wrapped.
4. Handshake:
   - Pulse while DONE with vectorAck low: pulse dropped, overflow=1, outputVector unchanged.
   - Pulse in the same cycle as vectorAck: the value appears at out[0] two cycles later and rowIdx=1.
   - A pulse during FLUSH sets overflow.
5. Reset mid-collection after 5 rows: rowIdx=0, vectorValid=0, outputVector=0. 16 further pulses then complete a fresh vector correctly. Pulses with gaps of 0–3 idle cycles between them give identical results.
